// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter.
// An 8-bit operand is accepted in IDLE, converted LSB-first over 8 SHIFT
// cycles, and the result is held in DONE until out_ready handshakes it.
// For a negative operand the magnitude is formed by the copy-until-first-one,
// then-invert rule, so no adder is needed.
// Build option: define SIGNMAG_SAT_EN to saturate the -128 magnitude to 7'h7F
// instead of wrapping it to 7'h00.
module twos_to_signmag_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sign,
  output logic [6:0] out_mag,
  output logic       out_ovf,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic [7:0]  shift_q;
  logic [7:0]  result_q;
  logic [2:0]  cnt_q;
  logic        sign_q;
  logic        seen_one_q;
  logic        min_q;       // operand was 8'h80

  logic        cur_bit;
  logic        out_bit;
  logic [7:0]  result_next;
  logic [6:0]  final_mag;

  // Form the current serial result bit and the magnitude as of the last shift.
  always_comb begin
    cur_bit     = shift_q[0];
    out_bit     = (sign_q && seen_one_q) ? ~cur_bit : cur_bit;
    // Result fills from the MSB end so that after 8 shifts bit 0 is the first bit.
    result_next = {out_bit, result_q[7:1]};
`ifdef SIGNMAG_SAT_EN
    final_mag   = min_q ? 7'h7F : result_next[6:0];
`else
    final_mag   = result_next[6:0];
`endif
  end

  // Control FSM with datapath and registered result fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= 8'h00;
      result_q   <= 8'h00;
      cnt_q      <= 3'd0;
      sign_q     <= 1'b0;
      seen_one_q <= 1'b0;
      min_q      <= 1'b0;
      out_sign   <= 1'b0;
      out_mag    <= 7'h00;
      out_ovf    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            shift_q    <= in_data;
            sign_q     <= in_data[7];
            min_q      <= (in_data == 8'h80);
            cnt_q      <= 3'd0;
            seen_one_q <= 1'b0;
            result_q   <= 8'h00;
            state_q    <= StShift;
          end
        end
        StShift: begin
          shift_q    <= {1'b0, shift_q[7:1]};
          result_q   <= result_next;
          seen_one_q <= seen_one_q | cur_bit;
          cnt_q      <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            out_sign <= sign_q;
            out_mag  <= final_mag;
            out_ovf  <= min_q;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_ovf <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and status flags decoded straight from the state register.
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
  end

endmodule
